// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types: fetch states, fault codes, memory defaults
//
// Purpose: types and constants shared by the fetch unit and the core FSM's
//          exception logic.
// Contents:
//   fetch_state_t   - fetch unit FSM encoding
//   FAULT_*         - 2-bit fetch fault codes reported on fault
//   DEF_ADDR_W      - default RAM address width
//   DEF_RAM_LATENCY - default RAM read latency in cycles
package proc_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_ISSUE = 3'd1,
        FS_DRAIN = 3'd2,
        FS_DONE  = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_RAM_LATENCY = 2;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multi-cycle byte-wide instruction fetch stage
//
// Purpose: reads one 32-bit little-endian instruction from a byte-wide RAM,
//          one byte per cycle, and holds it until the core acknowledges it.
//          Misaligned or out-of-range PCs are reported as faults with no RAM
//          access.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   fetch_req    start a fetch at fetch_pc (sampled only when accepting)
//   fetch_pc     byte address of the instruction
//   instr_ack    core consumed instr / fault
//   fetch_flush  abort the current fetch, highest priority
//   busy         state is not IDLE
//   instr_valid  instr holds a complete word
//   instr        fetched instruction
//   fault        00 none, 01 misaligned, 10 out of range
//   ram_addr     RAM read address (registered)
//   ram_rden     RAM read enable (registered)
//   ram_q        RAM read data, valid RAM_LATENCY cycles after the address
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    input  logic              instr_ack,
    input  logic              fetch_flush,
    output logic              busy,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [1:0]        fault,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [7:0]        ram_q
);

    fetch_state_t           state;
    logic [1:0]             issue_k;
    // Tag pipeline: one entry per read in flight, aligned so the last stage
    // is valid exactly in the cycle its byte is present on ram_q.
    logic [RAM_LATENCY-1:0] tag_v;
    logic [1:0]             tag_idx [RAM_LATENCY];

    logic                   accept;
    logic [1:0]             req_fault;
    logic                   cap_v;
    logic [1:0]             cap_idx;

    always_comb begin
        req_fault = FAULT_NONE;
        if (fetch_pc[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGN;
        end else if ((fetch_pc >> ADDR_W) != 32'd0) begin
            req_fault = FAULT_RANGE;
        end
        accept  = fetch_req && ((state == FS_IDLE) ||
                  (((state == FS_DONE) || (state == FS_FAULT)) && instr_ack));
        cap_v   = tag_v[RAM_LATENCY-1];
        cap_idx = tag_idx[RAM_LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FS_IDLE;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            fault       <= FAULT_NONE;
            ram_addr    <= '0;
            ram_rden    <= 1'b0;
            issue_k     <= 2'd0;
            tag_v       <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_idx[i] <= 2'd0;
            end
        end else if (fetch_flush) begin
            // Dropping the tags discards bytes still returning from the RAM;
            // instr deliberately keeps its last value.
            state       <= FS_IDLE;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= FAULT_NONE;
            ram_addr    <= '0;
            ram_rden    <= 1'b0;
            issue_k     <= 2'd0;
            tag_v       <= '0;
        end else begin
            // The read presented this cycle enters the tag pipeline at its end.
            tag_v[0]   <= ram_rden;
            tag_idx[0] <= issue_k;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end

            if (cap_v) begin
                instr[{cap_idx, 3'b000} +: 8] <= ram_q;
            end

            case (state)
                FS_IDLE, FS_DONE, FS_FAULT: begin
                    if (accept) begin
                        busy        <= 1'b1;
                        instr_valid <= 1'b0;
                        instr       <= 32'd0;
                        fault       <= req_fault;
                        if (req_fault != FAULT_NONE) begin
                            state <= FS_FAULT;
                        end else begin
                            state    <= FS_ISSUE;
                            ram_addr <= fetch_pc[ADDR_W-1:0];
                            ram_rden <= 1'b1;
                            issue_k  <= 2'd0;
                        end
                    end else if ((state != FS_IDLE) && instr_ack) begin
                        state       <= FS_IDLE;
                        busy        <= 1'b0;
                        instr_valid <= 1'b0;
                        fault       <= FAULT_NONE;
                    end
                end
                FS_ISSUE: begin
                    if (issue_k == 2'd3) begin
                        state    <= FS_DRAIN;
                        ram_rden <= 1'b0;
                    end else begin
                        issue_k  <= issue_k + 2'd1;
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                FS_DRAIN: begin
                    if (cap_v && (cap_idx == 2'd3)) begin
                        state       <= FS_DONE;
                        instr_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= FS_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int ADDR_W      = 16;
    localparam int RAM_LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_pc = 32'd0;
    logic              instr_ack = 1'b0;
    logic              fetch_flush = 1'b0;
    logic              busy;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [1:0]        fault;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rden;
    logic [7:0]        ram_q;

    logic [7:0] mem [0:65535];
    logic [7:0] pipe [RAM_LATENCY];

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RAM_LATENCY(RAM_LATENCY)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .instr_ack   (instr_ack),
        .fetch_flush (fetch_flush),
        .busy        (busy),
        .instr_valid (instr_valid),
        .instr       (instr),
        .fault       (fault),
        .ram_addr    (ram_addr),
        .ram_rden    (ram_rden),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: byte for the address driven in cycle c appears in c+RAM_LATENCY;
    // idle reads return a marker byte so stray captures are visible.
    always @(posedge clk) begin
        pipe[0] <= ram_rden ? mem[ram_addr] : 8'hEE;
        for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[RAM_LATENCY-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_addr"},  32'(ram_addr), 32'd0);
        check({tag, "_rden"},  32'(ram_rden), 32'd0);
    endtask

    // Request must already be presented in the current cycle T; ends in T+7.
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] exp);
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 1) begin
                fetch_req = 1'b0;
                instr_ack = 1'b0;
            end
            if (n <= 4) begin
                check("issue_addr", 32'(ram_addr), pc + 32'(n - 1));
                check("issue_rden", 32'(ram_rden), 32'd1);
            end else begin
                check("drain_rden", 32'(ram_rden), 32'd0);
            end
            check("fetch_busy", 32'(busy), 32'd1);
            if (n < 7) begin
                check("valid_early", 32'(instr_valid), 32'd0);
            end else begin
                check("valid_rise", 32'(instr_valid), 32'd1);
                check("instr_word", instr, exp);
            end
        end
    endtask

    task automatic ack_only();
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        check("ack_valid", 32'(instr_valid), 32'd0);
        check("ack_busy", 32'(busy), 32'd0);
    endtask

    logic [31:0] fault_pc   [3];
    logic [1:0]  fault_code [3];

    initial begin
        mem[16'h0000] = 8'h93; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h50; mem[16'h0003] = 8'h00;
        mem[16'h0004] = 8'h13; mem[16'h0005] = 8'h01; mem[16'h0006] = 8'hF1; mem[16'h0007] = 8'hFF;
        mem[16'h0008] = 8'hB7; mem[16'h0009] = 8'h0A; mem[16'h000A] = 8'h00; mem[16'h000B] = 8'h00;
        mem[16'hFFFC] = 8'h78; mem[16'hFFFD] = 8'h56; mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;
        fault_pc[0] = 32'h0000_0006; fault_code[0] = 2'b01;
        fault_pc[1] = 32'h0001_0000; fault_code[1] = 2'b10;
        fault_pc[2] = 32'h0001_0002; fault_code[2] = 2'b01;

        tick();
        tick();
        check_idle("reset");
        check("reset_instr", instr, 32'd0);
        rst = 1'b1;
        tick();

        // Basic fetch at PC 0, then word held while not acknowledged.
        fetch_req = 1'b1; fetch_pc = 32'h0;
        run_fetch(32'h0, 32'h0050_0093);
        tick();
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, 32'h0050_0093);

        // Back-to-back: ack with a new request.
        instr_ack = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h4;
        run_fetch(32'h4, 32'hFFF1_0113);
        ack_only();

        // Faulting PCs: no RAM read, fault clears on ack.
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_pc = fault_pc[i];
            tick();
            fetch_req = 1'b0;
            check("fault_code", 32'(fault), 32'(fault_code[i]));
            check("fault_busy", 32'(busy), 32'd1);
            check("fault_rden", 32'(ram_rden), 32'd0);
            check("fault_valid", 32'(instr_valid), 32'd0);
            check("fault_instr", instr, 32'd0);
            tick();
            check("fault_rden_hold", 32'(ram_rden), 32'd0);
            check("fault_hold", 32'(fault), 32'(fault_code[i]));
            ack_only();
            check("fault_clear", 32'(fault), 32'd0);
        end

        // Top-of-memory word, no address wrap.
        fetch_req = 1'b1; fetch_pc = 32'h0000_FFFC;
        run_fetch(32'h0000_FFFC, 32'h1234_5678);
        ack_only();

        // Flush in the cycle after byte 1 issues, then immediate refetch at 8.
        fetch_req = 1'b1; fetch_pc = 32'h4;
        tick();
        fetch_req = 1'b0;
        tick();
        tick();
        fetch_flush = 1'b1;
        tick();
        fetch_flush = 1'b0;
        check_idle("flush");
        fetch_req = 1'b1; fetch_pc = 32'h8;
        run_fetch(32'h8, 32'h0000_0AB7);
        ack_only();

        // Asynchronous reset while in DRAIN.
        fetch_req = 1'b1; fetch_pc = 32'h0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            fetch_req = 1'b0;
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_instr", instr, 32'd0);
        tick();
        rst = 1'b1;
        check_idle("rst_release");
        fetch_req = 1'b1; fetch_pc = 32'h0;
        run_fetch(32'h0, 32'h0050_0093);
        ack_only();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Multi-cycle fetch stage for the RV32 processor: on request, reads one 32-bit instruction from the byte-wide `system_ram`, one byte per cycle.
- Assembles the bytes little-endian and holds the word for the DECODE stage until it is acknowledged.
- Sits between the core FSM's FETCH/WAIT_FETCH states and `system_ram`'s read port, and replaces the fixed wait-count fetch.
- Flags misaligned and out-of-range PCs instead of issuing RAM reads.

## Interface
- `ADDR_W`, 16, RAM address width; a PC must fit in `ADDR_W` bits.
- `RAM_LATENCY`, 2, cycles from the cycle `ram_addr`/`ram_rden` are driven to the cycle the byte is valid on `ram_q` (≥1).

Ports:
- `clk` in 1: system clock (CLOCK_50); one clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: start a fetch at `fetch_pc`; sampled only when accepting (IDLE, or DONE/FAULT with `instr_ack`).
- `fetch_pc` in 32: byte address of the instruction.
- `instr_ack` in 1: core consumed `instr` / fault.
- `fetch_flush` in 1: abort the current fetch; has priority over all other inputs.
- `busy` out 1: high whenever state ≠ IDLE.
- `instr_valid` out 1: `instr` holds a complete word.
- `instr` out 32: fetched instruction.
- `fault` out 2: 00 none, 01 misaligned (`fetch_pc[1:0]`≠0), 10 out of range (`fetch_pc[31:ADDR_W]`≠0); misaligned wins if both apply.
- `ram_addr` out ADDR_W: RAM address (registered).
- `ram_rden` out 1: RAM read enable (registered).
- `ram_q` in 8: RAM read data.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE, FAULT.
- **IDLE**, `fetch_req`=1:
  - PC aligned and in range: latch PC, clear the byte registers, go to ISSUE.
  - Otherwise: latch `fault`, go to FAULT; no RAM access.
- **ISSUE** (4 cycles): issue counter k = 0..3 drives `ram_addr` = PC+k, `ram_rden`=1.
  - A RAM_LATENCY-deep tag shift register tracks the byte index in flight.
  - After k=3, go to DRAIN; `ram_rden`=0.
- **Capture**: when a tag emerges from the shift register, store `ram_q` into `instr[8k+7:8k]`. Capture happens in both ISSUE and DRAIN.
- **DRAIN**: when byte 3 is captured, go to DONE.
- **DONE**: `instr_valid`=1; `instr` is stable.
  - `instr_ack`=1 and `fetch_req`=1: handle as a new request from IDLE (back-to-back fetch).
  - `instr_ack`=1 alone: go to IDLE.
- **FAULT**: `fault` held, `instr_valid`=0, `instr`=0.
  - `instr_ack` exits exactly as from DONE.
  - `fault` clears on exit unless the new request also faults.
- **Flush**: `fetch_flush`=1 in any state sends the FSM to IDLE next cycle and clears the tag register, so in-flight bytes are discarded.
  - Outputs go to their reset values, except `instr`, which keeps its last value.
- **Address arithmetic**: done in ADDR_W bits. PCs are aligned and range-checked, so PC+3 ≤ 0xFFFF and no wrap can occur.
- `instr_ack` outside DONE/FAULT is ignored.
- `fetch_req` in ISSUE/DRAIN is ignored; it is not queued.

## Timing
- Reset values: state IDLE, `busy`=0, `instr_valid`=0, `instr`=0, `fault`=00, `ram_addr`=0, `ram_rden`=0, tags cleared.
- Reset asserted mid-fetch: immediate return to reset values; RAM data still returning is ignored.
- Request accepted in cycle T:
  - `ram_addr`=PC+k with `ram_rden`=1 in cycle T+1+k.
  - Byte k captured at the end of cycle T+1+k+RAM_LATENCY.
  - `instr_valid` rises in cycle T+5+RAM_LATENCY (T+7 at default).
- Faulting request in cycle T: `fault` valid in cycle T+1; `busy`=1.
- Ack in cycle A: `instr_valid` low in A+1. With a back-to-back request, the first address appears in A+1.
- Throughput: one instruction per 5+RAM_LATENCY cycles plus ack latency.

## Structure
- Shared package `proc_pkg`:
  - fetch state enum;
  - fault-code constants FAULT_NONE/MISALIGN/RANGE;
  - default ADDR_W and RAM_LATENCY;
  - these are reused by the core FSM's exception logic.
- No sub-module; the counter, tag shift register and byte assembly are inline.

## Test plan
- RAM bytes 0x0000..0x0003 = 93,00,50,00; request PC=0 in cycle T → `instr`=0x00500093, `instr_valid` rises at T+7, `ram_addr` sequence 0,1,2,3 in T+1..T+4.
- Back-to-back: ack together with request PC=4 (bytes 13,01,F1,FF) → next `ram_addr`=4 the following cycle; `instr`=0xFFF10113.
- PC=0x0000_0006 → `fault`=01 with no `ram_rden` pulse; PC=0x0001_0000 → `fault`=10; PC=0x0001_0002 → `fault`=01; each clears on ack.
- Boundary: PC=0xFFFC → addresses FFFC..FFFF, no wrap, correct word.
- Flush in the cycle after byte 1 issues → IDLE next cycle, `instr_valid` never rises; late `ram_q` data does not corrupt an immediate refetch at PC=8.
- `rst` low in DRAIN → all outputs at reset values asynchronously; after release, a new fetch completes in 7 cycles.
